// File: rtl/led4_seq_ctrl.sv
// led4_seq_ctrl
//   Sequencer for the 4-LED pipe. Holds the LED pattern and advances it one
//   step every TICK_DIV clocks in the selected mode (rotate left, rotate
//   right, bounce, blink). start/stop strobes move it between IDLE, RUN and
//   HOLD.
//
// Ports
//   clock     in   1      system clock, rising edge
//   reset_n   in   1      asynchronous active-low reset
//   start     in   1      strobe: IDLE->RUN, HOLD->RUN
//   stop      in   1      strobe: RUN->HOLD, HOLD->IDLE (wins over start)
//   mode      in   2      0 rot-left, 1 rot-right, 2 bounce, 3 blink
//   mode_vld  in   1      load mode (honoured in IDLE only)
//   diode     out  LED_W  registered LED pattern
//   busy      out  1      high in RUN or HOLD
//   step      out  1      one-cycle pulse after each pattern advance
//
// Configuration
//   LED_SEQ_BOUNCE_EN  defined: mode 2 bounces between the end LEDs using a
//                      direction register. Undefined: no direction register,
//                      mode 2 behaves exactly like mode 0.
module led4_seq_ctrl #(
  parameter int LED_W    = 4,
  parameter int TICK_DIV = 25,
  parameter int CNT_W    = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic             mode_vld,
  output logic [LED_W-1:0] diode,
  output logic             busy,
  output logic             step
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
  localparam logic [LED_W-1:0] LED_LSB = {{(LED_W-1){1'b0}}, 1'b1};
  localparam logic [LED_W-1:0] LED_MSB = {1'b1, {(LED_W-1){1'b0}}};

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       mode_r;
`ifdef LED_SEQ_BOUNCE_EN
  logic             dir_right;
`endif

  function automatic logic [LED_W-1:0] init_pattern(input logic [1:0] m);
    case (m)
      2'd1:    return LED_MSB;
      2'd3:    return '1;
      default: return LED_LSB;
    endcase
  endfunction

  function automatic logic [LED_W-1:0] rot_left(input logic [LED_W-1:0] p);
    return {p[LED_W-2:0], p[LED_W-1]};
  endfunction

  function automatic logic [LED_W-1:0] rot_right(input logic [LED_W-1:0] p);
    return {p[0], p[LED_W-1:1]};
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      diode     <= '0;
      busy      <= 1'b0;
      step      <= 1'b0;
      cnt       <= '0;
      mode_r    <= 2'd0;
`ifdef LED_SEQ_BOUNCE_EN
      dir_right <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          step  <= 1'b0;
          diode <= '0;
          if (mode_vld)
            mode_r <= mode;
          // stop has priority, so start+stop together leaves us idle
          if (start && !stop) begin
            state     <= RUN;
            busy      <= 1'b1;
            cnt       <= '0;
            diode     <= init_pattern(mode_vld ? mode : mode_r);
`ifdef LED_SEQ_BOUNCE_EN
            dir_right <= 1'b0;
`endif
          end
        end

        RUN: begin
          if (stop) begin
            // freeze pattern and prescaler where they are
            state <= HOLD;
            step  <= 1'b0;
          end else if (cnt == CNT_MAX) begin
            cnt  <= '0;
            step <= 1'b1;
            case (mode_r)
              2'd1: diode <= rot_right(diode);
              2'd3: diode <= ~diode;
`ifdef LED_SEQ_BOUNCE_EN
              2'd2: begin
                // turn around on the step that lands on an end LED so each
                // endpoint is shown exactly once per sweep
                if (!dir_right) begin
                  diode <= diode << 1;
                  if (diode[LED_W-2])
                    dir_right <= 1'b1;
                end else begin
                  diode <= diode >> 1;
                  if (diode[1])
                    dir_right <= 1'b0;
                end
              end
`endif
              default: diode <= rot_left(diode);
            endcase
          end else begin
            cnt  <= cnt + 1'b1;
            step <= 1'b0;
          end
        end

        HOLD: begin
          step <= 1'b0;
          if (stop) begin
            state <= IDLE;
            diode <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (start) begin
            // resume with the frozen prescaler value
            state <= RUN;
          end
        end

        default: begin
          state <= IDLE;
          diode <= '0;
          busy  <= 1'b0;
          step  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led4_seq_ctrl.sv
// tb_led4_seq_ctrl
//   Bench for led4_seq_ctrl with LED_W=4, TICK_DIV=4, 40ns clock.
//   Constant vector table, hand-written multi-cycle sequences, then random
//   strobes checked against a reference model that derives the pattern from
//   the number of advances since start.
module tb_led4_seq_ctrl;

  localparam int W    = 4;
  localparam int TDIV = 4;

  logic         clock;
  logic         reset_n;
  logic         start;
  logic         stop;
  logic [1:0]   mode;
  logic         mode_vld;
  logic [W-1:0] diode;
  logic         busy;
  logic         step;

  led4_seq_ctrl #(
    .LED_W   (W),
    .TICK_DIV(TDIV),
    .CNT_W   (3)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .stop    (stop),
    .mode    (mode),
    .mode_vld(mode_vld),
    .diode   (diode),
    .busy    (busy),
    .step    (step)
  );

  initial begin
    clock = 1'b0;
    forever #20 clock = ~clock;
  end

  int n_vec = 0;
  int n_err = 0;

  // reference model: state 0 idle, 1 run, 2 hold
  int m_state = 0;
  int m_mode  = 0;
  int m_rc    = 0;  // run clocks counted since start (frozen in hold)
  int m_n     = 0;  // pattern advances since start
  bit m_step  = 0;

  function automatic logic [W-1:0] model_pat(input int md, input int n);
    int eff;
    int k;
    eff = md;
`ifndef LED_SEQ_BOUNCE_EN
    if (eff == 2) eff = 0;
`endif
    case (eff)
      0: return 4'b0001 << (n % W);
      1: return 4'b1000 >> (n % W);
      2: begin
        k = n % (2 * W - 2);
        if (k >= W) k = 2 * W - 2 - k;
        return 4'b0001 << k;
      end
      default: return (n % 2 == 0) ? 4'b1111 : 4'b0000;
    endcase
  endfunction

  function automatic logic [5:0] model_out();
    logic [W-1:0] d;
    d = (m_state == 0) ? 4'b0000 : model_pat(m_mode, m_n);
    return {d, (m_state != 0), m_step};
  endfunction

  task automatic model_reset();
    m_state = 0; m_mode = 0; m_rc = 0; m_n = 0; m_step = 0;
  endtask

  task automatic model_edge(input bit s, input bit p, input int md, input bit v);
    case (m_state)
      0: begin
        m_step = 0;
        if (v) m_mode = md;
        if (s && !p) begin
          m_state = 1; m_rc = 0; m_n = 0;
        end
      end
      1: begin
        if (p) begin
          m_state = 2; m_step = 0;
        end else begin
          m_rc++;
          if (m_rc % TDIV == 0) begin
            m_n++; m_step = 1;
          end else begin
            m_step = 0;
          end
        end
      end
      default: begin
        m_step = 0;
        if (p) m_state = 0;
        else if (s) m_state = 1;
      end
    endcase
  endtask

  task automatic chk(input string nm, input logic [5:0] exp);
    logic [5:0] act;
    act = {diode, busy, step};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got diode=%b busy=%b step=%b, want diode=%b busy=%b step=%b",
               nm, act[5:2], act[1], act[0], exp[5:2], exp[1], exp[0]);
    end
  endtask

  // drive inputs, take one rising edge, update the model, settle
  task automatic cyc(input bit s, input bit p, input logic [1:0] md, input bit v);
    start = s; stop = p; mode = md; mode_vld = v;
    @(posedge clock);
    model_edge(s, p, int'(md), v);
    #1;
    start = 0; stop = 0; mode_vld = 0;
  endtask

  typedef struct {
    bit           st;
    bit           sp;
    logic [1:0]   md;
    bit           mv;
    logic [W-1:0] d;
    bit           b;
    bit           s;
  } vec_t;

  vec_t tbl[19];

  // start in mode md, check 28 clocks against 8 expected patterns, then stop twice
  task automatic run_seq(input string nm, input logic [1:0] md, input logic [7:0][3:0] pats);
    cyc(1, 0, md, 1);
    chk({nm, "_start"}, {pats[7], 1'b1, 1'b0});
    for (int i = 1; i <= 7 * TDIV; i++) begin
      cyc(0, 0, 2'd0, 0);
      chk(nm, {pats[7 - i / TDIV], 1'b1, (i % TDIV == 0)});
    end
    cyc(0, 1, 2'd0, 0);
    chk({nm, "_hold"}, {pats[0], 1'b1, 1'b0});
    cyc(0, 1, 2'd0, 0);
    chk({nm, "_idle"}, 6'b0000_0_0);
  endtask

  initial begin
    logic [7:0][3:0] bounce_pats;

    tbl[0]  = '{1, 0, 2'd0, 1, 4'b0001, 1, 0};
    tbl[1]  = '{0, 0, 2'd0, 0, 4'b0001, 1, 0};
    tbl[2]  = '{0, 0, 2'd0, 0, 4'b0001, 1, 0};
    tbl[3]  = '{0, 0, 2'd0, 0, 4'b0001, 1, 0};
    tbl[4]  = '{0, 0, 2'd0, 0, 4'b0010, 1, 1};
    tbl[5]  = '{0, 0, 2'd0, 0, 4'b0010, 1, 0};
    tbl[6]  = '{0, 0, 2'd0, 0, 4'b0010, 1, 0};
    tbl[7]  = '{0, 0, 2'd0, 0, 4'b0010, 1, 0};
    tbl[8]  = '{0, 0, 2'd0, 0, 4'b0100, 1, 1};
    tbl[9]  = '{0, 0, 2'd0, 0, 4'b0100, 1, 0};
    tbl[10] = '{0, 0, 2'd0, 0, 4'b0100, 1, 0};
    tbl[11] = '{0, 0, 2'd0, 0, 4'b0100, 1, 0};
    tbl[12] = '{0, 0, 2'd0, 0, 4'b1000, 1, 1};
    tbl[13] = '{0, 0, 2'd0, 0, 4'b1000, 1, 0};
    tbl[14] = '{0, 0, 2'd0, 0, 4'b1000, 1, 0};
    tbl[15] = '{0, 0, 2'd0, 0, 4'b1000, 1, 0};
    tbl[16] = '{0, 0, 2'd0, 0, 4'b0001, 1, 1};
    tbl[17] = '{0, 1, 2'd0, 0, 4'b0001, 1, 0};
    tbl[18] = '{0, 1, 2'd0, 0, 4'b0000, 0, 0};

    reset_n = 1; start = 0; stop = 0; mode = 0; mode_vld = 0;

    // reset pulse 10..30ns, no other stimulus
    #10 reset_n = 0;
    #5  chk("reset_early", 6'b0000_0_0);
    #10 chk("reset_late", 6'b0000_0_0);
    #5  reset_n = 1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 2'd0, 0);
      chk("post_reset_idle", 6'b0000_0_0);
    end

    // table: mode 0 rotate-left run, then stop, stop
    for (int i = 0; i < 19; i++) begin
      cyc(tbl[i].st, tbl[i].sp, tbl[i].md, tbl[i].mv);
      chk($sformatf("tbl%0d", i), {tbl[i].d, tbl[i].b, tbl[i].s});
    end

    run_seq("rot_right", 2'd1, {4'b1000, 4'b0100, 4'b0010, 4'b0001,
                                4'b1000, 4'b0100, 4'b0010, 4'b0001});
    run_seq("blink", 2'd3, {4'b1111, 4'b0000, 4'b1111, 4'b0000,
                            4'b1111, 4'b0000, 4'b1111, 4'b0000});
`ifdef LED_SEQ_BOUNCE_EN
    bounce_pats = {4'b0001, 4'b0010, 4'b0100, 4'b1000,
                   4'b0100, 4'b0010, 4'b0001, 4'b0010};
`else
    bounce_pats = {4'b0001, 4'b0010, 4'b0100, 4'b1000,
                   4'b0001, 4'b0010, 4'b0100, 4'b1000};
`endif
    run_seq("bounce", 2'd2, bounce_pats);

    // hold at 0100 with prescaler at 1, then resume
    cyc(1, 0, 2'd0, 1);
    for (int i = 0; i < 9; i++) cyc(0, 0, 2'd0, 0);
    chk("hold_pre", 6'b0100_1_0);
    cyc(0, 1, 2'd0, 0);
    chk("hold_enter", 6'b0100_1_0);
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 2'd0, 0);
      chk("hold_frozen", 6'b0100_1_0);
    end
    cyc(1, 0, 2'd0, 0);
    chk("resume_edge", 6'b0100_1_0);
    cyc(0, 0, 2'd0, 0);
    chk("resume_1", 6'b0100_1_0);
    cyc(0, 0, 2'd0, 0);
    chk("resume_2", 6'b0100_1_0);
    cyc(0, 0, 2'd0, 0);
    chk("resume_3", 6'b1000_1_1);
    cyc(0, 1, 2'd0, 0);
    chk("stop1", 6'b1000_1_0);
    cyc(0, 1, 2'd0, 0);
    chk("stop2", 6'b0000_0_0);

    // start+stop together in idle stays idle
    cyc(1, 1, 2'd1, 1);
    chk("start_stop_idle", 6'b0000_0_0);
    cyc(0, 0, 2'd0, 0);
    chk("start_stop_idle2", 6'b0000_0_0);

    // mode change mid-run is ignored
    cyc(1, 0, 2'd0, 1);
    chk("mid_mode_start", 6'b0001_1_0);
    cyc(0, 0, 2'd0, 0);
    cyc(1, 0, 2'd1, 1);
    chk("mid_mode_ign", 6'b0001_1_0);
    cyc(0, 0, 2'd0, 0);
    cyc(0, 0, 2'd0, 0);
    chk("mid_mode_adv", 6'b0010_1_1);

    // asynchronous reset between edges
    #5 reset_n = 0;
    #1 chk("async_reset", 6'b0000_0_0);
    model_reset();
    #10 reset_n = 1;
    cyc(0, 0, 2'd0, 0);
    chk("after_async", 6'b0000_0_0);

    // random strobes against the model
    for (int i = 0; i < 1500; i++) begin
      cyc($urandom_range(0, 11) == 0, $urandom_range(0, 15) == 0,
          2'($urandom_range(0, 3)), $urandom_range(0, 3) == 0);
      chk($sformatf("rand%0d", i), model_out());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
